// File: rtl/iic_wb_master.sv
// iic_wb_master: Wishbone master that sequences one IIC register read/write through the KAT ADC IIC controller.
// Ports: wb_clk_i / wb_rst_n_i (async active-low reset); cmd_valid/cmd_rd/cmd_dev/cmd_reg/cmd_wdata command in;
// busy/done/error/rd_data status out; wbm_* classic single-cycle Wishbone master.
// Option IIC_WB_MASTER_TIMEOUT_EN: bounds STATUS polling to C_POLL_LIMIT reads, then ends with error.
module iic_wb_master #(
  parameter logic [31:0] C_BASEADDR = 32'h0000_0000,
  parameter int C_POLL_LIMIT = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid,
  input  logic        cmd_rd,
  input  logic [6:0]  cmd_dev,
  input  logic [7:0]  cmd_reg,
  input  logic [7:0]  cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  rd_data,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  typedef enum logic [3:0] {S_IDLE, S_CLR, S_BLK, S_OPS, S_UNBLK, S_POLL, S_RXRD, S_POP, S_DONE} state_t;
  state_t r_state, w_state_n;
  logic r_cyc, r_we, r_rd, r_again, r_err;
  logic [31:0] r_adr, r_dat;
  logic [6:0] r_dev;
  logic [7:0] r_reg, r_wdat, r_rx, r_rd_data;
  logic [1:0] r_idx;
  logic w_ack, w_accept, w_start, w_fail, w_tmo, w_we, w_unused;
  logic [1:0] w_off;
  logic [11:0] w_op;
  logic [31:0] w_dat;
  assign w_ack = r_cyc & wbm_ack_i;
  assign w_accept = r_state == S_IDLE && cmd_valid;
  // a new access is launched only after the previous one has dropped cyc, which yields the idle gap
  assign w_start = !r_cyc && r_state != S_IDLE && r_state != S_DONE;
  assign w_unused = ^wbm_dat_i[31:9];
  assign w_op = r_idx == 2'd0 ? {4'h2, r_dev, 1'b0}
              : r_idx == 2'd1 ? {4'h0, r_reg}
              : r_idx == 2'd2 ? (r_rd ? {4'h2, r_dev, 1'b1} : {4'h4, r_wdat})
              : 12'h500;
`ifdef IIC_WB_MASTER_TIMEOUT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) r_cnt <= '0;
    else if (w_accept) r_cnt <= '0;
    else if (r_state == S_POLL && w_ack) r_cnt <= r_cnt + 16'd1;
  assign w_tmo = r_cnt + 16'd1 == 16'(C_POLL_LIMIT);
`else
  localparam int unused_poll_limit = C_POLL_LIMIT;
  assign w_tmo = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    w_fail = 1'b0;
    w_we = 1'b1;
    w_off = 2'd0;
    w_dat = '0;
    case (r_state)
      S_IDLE: w_state_n = cmd_valid ? S_CLR : S_IDLE;
      S_CLR: begin
        w_off = 2'd2;
        w_state_n = w_ack ? S_BLK : S_CLR;
      end
      S_BLK: begin
        w_off = 2'd3;
        w_dat = 32'd1;
        w_state_n = w_ack ? S_OPS : S_BLK;
      end
      S_OPS: begin
        w_dat = {20'd0, w_op};
        w_state_n = w_ack && r_idx == (r_rd ? 2'd3 : 2'd2) ? S_UNBLK : S_OPS;
      end
      S_UNBLK: begin
        w_off = 2'd3;
        w_state_n = w_ack ? S_POLL : S_UNBLK;
      end
      S_POLL: begin
        w_we = 1'b0;
        w_off = 2'd2;
        if (w_ack) begin
          // op_error wins over data-ready; a write ends after its second STATUS read
          if (wbm_dat_i[8]) begin
            w_state_n = S_DONE;
            w_fail = 1'b1;
          end else if (r_rd && !wbm_dat_i[0]) w_state_n = S_RXRD;
          else if (!r_rd && r_again) w_state_n = S_DONE;
          else if (w_tmo) begin
            w_state_n = S_DONE;
            w_fail = 1'b1;
          end
        end
      end
      S_RXRD: begin
        w_we = 1'b0;
        w_off = 2'd1;
        w_state_n = w_ack ? S_POP : S_RXRD;
      end
      S_POP: begin
        w_off = 2'd1;
        w_state_n = w_ack ? S_DONE : S_POP;
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      r_cyc <= 1'b0;
      r_we <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_rd <= 1'b0;
      r_dev <= '0;
      r_reg <= '0;
      r_wdat <= '0;
      r_idx <= '0;
      r_again <= 1'b0;
      r_err <= 1'b0;
      r_rx <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_rd <= cmd_rd;
        r_dev <= cmd_dev;
        r_reg <= cmd_reg;
        r_wdat <= cmd_wdata;
        r_idx <= '0;
        r_again <= 1'b0;
        r_err <= 1'b0;
        r_rx <= '0;
      end
      if (w_start) begin
        r_cyc <= 1'b1;
        r_we <= w_we;
        r_adr <= C_BASEADDR + {28'd0, w_off, 2'b00};
        r_dat <= w_dat;
      end else if (w_ack) r_cyc <= 1'b0;
      if (r_state == S_OPS && w_ack) r_idx <= r_idx + 2'd1;
      if (r_state == S_POLL && w_ack) r_again <= 1'b1;
      if (r_state == S_RXRD && w_ack) r_rx <= wbm_dat_i[7:0];
      if (w_fail) r_err <= 1'b1;
      // the received byte becomes visible only as the command completes
      if (w_state_n == S_DONE && r_state != S_DONE) r_rd_data <= r_rx;
    end
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign error = r_err;
  assign rd_data = r_rd_data;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o = r_we;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
endmodule

// File: tb/tb_iic_wb_master.sv
// tb_iic_wb_master: randomized self-checking bench for iic_wb_master against a transaction-level model.
module tb_iic_wb_master;
  localparam logic [31:0] BASE = 32'h1000_0100;
`ifdef IIC_WB_MASTER_TIMEOUT_EN
  localparam int LIMIT = 8;
  localparam bit TMO = 1'b1;
`else
  localparam int LIMIT = 4096;
  localparam bit TMO = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b1;
  logic cmd_valid = 1'b0, cmd_rd = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0, cmd_wdata = '0;
  logic busy, done, error;
  logic [7:0] rd_data;
  logic cyc, stb, we;
  logic [3:0] sel;
  logic [31:0] adr, dato;
  logic [31:0] dati = '0;
  logic ack = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  iic_wb_master #(.C_BASEADDR(BASE), .C_POLL_LIMIT(LIMIT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .cmd_valid(cmd_valid), .cmd_rd(cmd_rd), .cmd_dev(cmd_dev),
    .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .busy(busy), .done(done), .error(error), .rd_data(rd_data),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dato),
    .wbm_dat_i(dati), .wbm_ack_i(ack)
  );
  // slave model: ack after dly wait cycles, scripted STATUS replies, logs {we, adr, wdata}
  int dly = 0, wcnt = 0, viol = 0;
  logic [31:0] st_q[$];
  logic [31:0] st_stuck = 32'h1;
  logic [7:0] rx_byte = '0;
  logic [64:0] log_q[$];
  logic [64:0] hold;
  always @(negedge clk) begin
    if (ack) begin
      if (cyc) viol++;
      ack = 1'b0;
      wcnt = 0;
    end else if (cyc && stb) begin
      if (sel !== 4'hF) viol++;
      if (wcnt == 0) hold = {we, adr, dato};
      else if ({we, adr, dato} !== hold) viol++;
      if (wcnt == dly) begin
        ack = 1'b1;
        log_q.push_back({we, adr, we ? dato : 32'h0});
        if (!we) begin
          if (adr == BASE + 32'd8) begin
            if (st_q.size() > 0) dati = st_q.pop_front();
            else dati = st_stuck;
          end else if (adr == BASE + 32'd4) dati = {$urandom_range(0, 255) << 8, rx_byte};
          else dati = 32'hDEAD_BEEF;
        end
      end else wcnt++;
    end else wcnt = 0;
  end
  // reference model: expected bus transactions and outcome from the command and STATUS script
  logic [64:0] exp_q[$];
  logic exp_err;
  logic [7:0] exp_rd;
  function automatic logic [64:0] wr(input int off, input logic [31:0] d);
    return {1'b1, BASE + off, d};
  endfunction
  function automatic logic [64:0] rdx(input int off);
    return {1'b0, BASE + off, 32'h0};
  endfunction
  task automatic model(input bit rd, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] rx);
    logic [31:0] sc[$];
    logic [31:0] s;
    sc = st_q;
    exp_q = {};
    exp_err = 1'b0;
    exp_rd = 8'h00;
    exp_q.push_back(wr(8, 0));
    exp_q.push_back(wr(12, 1));
    exp_q.push_back(wr(0, 32'h200 + 32'(dev) * 2));
    exp_q.push_back(wr(0, 32'(rg)));
    if (rd) begin
      exp_q.push_back(wr(0, 32'h201 + 32'(dev) * 2));
      exp_q.push_back(wr(0, 32'h500));
    end else exp_q.push_back(wr(0, 32'h400 + 32'(wd)));
    exp_q.push_back(wr(12, 0));
    for (int i = 0; i < 5000; i++) begin
      s = i < sc.size() ? sc[i] : st_stuck;
      exp_q.push_back(rdx(8));
      if (s[8]) begin
        exp_err = 1'b1;
        break;
      end
      if (rd && !s[0]) begin
        exp_q.push_back(rdx(4));
        exp_q.push_back(wr(4, 0));
        exp_rd = rx;
        break;
      end
      if (!rd && i == 1) break;
      if (TMO && i + 1 == LIMIT) begin
        exp_err = 1'b1;
        break;
      end
    end
  endtask
  task automatic do_cmd(input string nm, input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd, input logic [7:0] rx, input bit chk_lat, input bit chk_rd);
    int k, v0, n;
    model(rd, dev, rg, wd, rx);
    log_q = {};
    rx_byte = rx;
    v0 = viol;
    @(negedge clk);
    cmd_rd = rd; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_rd = 1'($urandom); cmd_dev = 7'($urandom); cmd_reg = 8'($urandom); cmd_wdata = 8'($urandom);
    k = 1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept: got %b expected 1", nm, busy); end
    while (done !== 1'b1 && k < 4000) begin
      cmd_valid = k == 3;
      @(negedge clk);
      k++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s done_timeout: got done=%b expected 1 within 4000 cycles", nm, done); end
    checks++;
    if (error !== exp_err) begin errors++; $display("FAIL %s error: got %b expected %b", nm, error, exp_err); end
    if (chk_rd) begin
      checks++;
      if (rd_data !== exp_rd) begin errors++; $display("FAIL %s rd_data: got %h expected %h", nm, rd_data, exp_rd); end
    end
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL %s access_count: got %0d expected %0d", nm, log_q.size(), exp_q.size());
    end
    n = log_q.size() < exp_q.size() ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s access[%0d] {we,adr,dat}: got %h expected %h", nm, i, log_q[i], exp_q[i]);
      end
    end
    checks++;
    if (viol !== v0) begin errors++; $display("FAIL %s bus_protocol: got %0d violations expected 0", nm, viol - v0); end
    if (chk_lat) begin
      checks++;
      if (k + 1 !== 2 * exp_q.size() + 2) begin
        errors++; $display("FAIL %s latency: got %0d expected %0d", nm, k + 1, 2 * exp_q.size() + 2);
      end
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin errors++; $display("FAIL %s after_done {done,busy}: got %b expected 00", nm, {done, busy}); end
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc, stb, we, busy, done, error} !== 6'b0) begin
      errors++; $display("FAIL reset_flags {cyc,stb,we,busy,done,error}: got %b expected 000000", {cyc, stb, we, busy, done, error});
    end
    checks++;
    if ({adr, dato} !== 64'h0) begin errors++; $display("FAIL reset_bus adr/dat: got %h/%h expected 0/0", adr, dato); end
    checks++;
    if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_write();
    dly = 0; st_q = {}; st_stuck = 32'h1;
    do_cmd("write", 1'b0, 7'h21, 8'h05, 8'hA5, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_read();
    dly = 0; st_q = {32'h1, 32'h1, 32'h0}; st_stuck = 32'h1;
    do_cmd("read", 1'b1, 7'h21, 8'h10, 8'h00, 8'h3C, 1'b1, 1'b1);
  endtask
  task automatic test_read_error();
    dly = 0; st_q = {32'h101}; st_stuck = 32'h1;
    do_cmd("read_err", 1'b1, 7'h21, 8'h10, 8'h00, 8'h77, 1'b1, 1'b0);
  endtask
  task automatic test_slow_ack();
    dly = 5; st_q = {}; st_stuck = 32'h1;
    do_cmd("slow_write", 1'b0, 7'h5A, 8'hC3, 8'h3C, 8'h00, 1'b0, 1'b0);
    st_q = {32'h1, 32'h0};
    do_cmd("slow_read", 1'b1, 7'h13, 8'h7E, 8'h00, 8'h96, 1'b0, 1'b1);
    dly = 0;
  endtask
  task automatic test_reset_mid();
    int n;
    dly = 0; st_q = {}; st_stuck = 32'h1; log_q = {};
    @(negedge clk);
    cmd_rd = 1'b0; cmd_dev = 7'h44; cmd_reg = 8'h01; cmd_wdata = 8'h02; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(log_q.size() >= 3 && cyc === 1'b1) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cyc !== 1'b1) begin errors++; $display("FAIL reset_mid reach_ops: got cyc=%b expected 1 within 100 cycles", cyc); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc, stb, busy} !== 3'b000) begin errors++; $display("FAIL reset_mid async {cyc,stb,busy}: got %b expected 000", {cyc, stb, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd("after_reset", 1'b0, 7'h21, 8'h05, 8'hA5, 8'h00, 1'b1, 1'b0);
  endtask
  task automatic test_random();
    bit rd;
    for (int n = 0; n < 16; n++) begin
      rd = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 3);
      st_q = {};
      st_stuck = 32'h1;
      if (rd) begin
        repeat ($urandom_range(0, 3)) st_q.push_back(($urandom & ~32'h101) | 32'h1);
        st_q.push_back(($urandom & ~32'h101) | ($urandom_range(0, 4) == 0 ? 32'h100 : 32'h0));
      end else repeat (2) st_q.push_back(($urandom & ~32'h100) | ($urandom_range(0, 5) == 0 ? 32'h100 : 32'h0));
      do_cmd("random", rd, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), dly == 0, rd);
    end
    dly = 0;
  endtask
`ifdef IIC_WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int polls;
    dly = 0; st_q = {}; st_stuck = 32'h1;
    do_cmd("timeout", 1'b1, 7'h21, 8'h10, 8'h00, 8'h55, 1'b1, 1'b1);
    polls = 0;
    foreach (log_q[i]) if (log_q[i] === rdx(8)) polls++;
    checks++;
    if (polls !== 8) begin errors++; $display("FAIL timeout status_reads: got %0d expected 8", polls); end
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_error();
    test_slow_ack();
    test_reset_mid();
    test_random();
`ifdef IIC_WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
